instr_fetch_unit: RTL and testbench

//  Front-end stage directly upstream of the control unit. Owns the program counter, drives the

---
 rtl/instr_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch front-end ahead of the control unit. Owns the fetch PC, issues
//   reads to a synchronous byte ROM (data one cycle after rom_en_o), queues
//   returned bytes in a small FIFO and presents the head byte with its PC.
//   The consumer pops with byte_ready_i. jump_en_i redirects fetch and
//   flushes the queue. halt_i parks the unit until the next jump.
//
//   Optional build macro: FETCH_BYPASS_EN. When it is defined, a returning
//   byte is shown on byte_out_o in its return cycle if the FIFO is empty.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   rom_en_o/addr_o    ROM read strobe and address
//   rom_data_i         ROM read data, one cycle after rom_en_o
//   byte_out_o/pc_o    head byte and its address
//   byte_valid_o       head byte valid
//   byte_ready_i       consumer pops the head byte this cycle
//   jump_en_i/addr_i   redirect fetch to jump_addr_i
//   halt_i, halted_o   stop issuing reads / parked indicator
//
// state  | meaning
// S_RUN  | issuing reads while FIFO credit allows
// S_HALT | no new reads; queued bytes still drain; leave only on jump
module instr_fetch_unit #(
   parameter int unsigned       ADDR_W     = 16,
   parameter int unsigned       DATA_W     = 8,
   parameter int unsigned       FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              rom_en_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i,
   output logic [DATA_W-1:0] byte_out_o,
   output logic [ADDR_W-1:0] byte_pc_o,
   output logic              byte_valid_o,
   input  logic              byte_ready_i,
   input  logic              jump_en_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              halt_i,
   output logic              halted_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic {S_RUN, S_HALT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] byte_pc_q, byte_pc_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              inflight_q, inflight_d;

   logic [CNT_W:0]    occ;
   logic              issue, ret, bypass, pop, fifo_pop, push;

   always_comb begin
      state_d = state_q;
      if (jump_en_i) begin
         state_d = S_RUN;
      end else if (halt_i) begin
         state_d = S_HALT;
      end
   end

   // Credit counts the byte still in flight; a same-cycle pop earns nothing.
   // A halt stops issuing in the very cycle it is sampled.
   assign occ   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
   assign issue = !rst_i && (state_q == S_RUN) && !jump_en_i && !halt_i
                  && (occ < DEPTH_C);
   assign ret   = inflight_q && !jump_en_i && !rst_i;

`ifdef FETCH_BYPASS_EN
   assign bypass = ret && (count_q == '0);
`else
   assign bypass = 1'b0;
`endif

   assign byte_valid_o = (count_q != '0) || bypass;
   assign pop          = byte_valid_o && byte_ready_i && !jump_en_i && !rst_i;
   // A bypassed byte that is popped immediately never enters the FIFO.
   assign fifo_pop     = pop && !bypass;
   assign push         = ret && !(bypass && pop);

   always_comb begin
      byte_out_o = '0;
      if (bypass) begin
         byte_out_o = rom_data_i;
      end else if (byte_valid_o) begin
         byte_out_o = mem_q[rd_ptr_q];
      end
   end

   assign rom_en_o   = issue;
   assign rom_addr_o = issue ? fetch_pc_q : '0;
   assign byte_pc_o  = byte_pc_q;
   assign halted_o   = (state_q == S_HALT);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      byte_pc_d  = byte_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      inflight_d = issue;
      if (jump_en_i) begin
         fetch_pc_d = jump_addr_i;
         byte_pc_d  = jump_addr_i;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (issue)    fetch_pc_d = fetch_pc_q + 1'b1;
         if (pop)      byte_pc_d  = byte_pc_q + 1'b1;
         if (fifo_pop) rd_ptr_d   = rd_ptr_q + 1'b1;
         if (push)     wr_ptr_d   = wr_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(push) - CNT_W'(fifo_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_RUN;
         fetch_pc_q <= RESET_PC;
         byte_pc_q  <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         byte_pc_q  <= byte_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= rom_data_i;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

`ifdef FETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif
   localparam int LAT_J = LAT + 1;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        rom_en;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data;
   logic [7:0]  byte_out;
   logic [15:0] byte_pc;
   logic        byte_valid;
   logic        byte_ready;
   logic        jump_en;
   logic [15:0] jump_addr;
   logic        halt;
   logic        halted;

   int n_chk = 0;
   int n_pass = 0;
   int pop_cnt = 0;
   int issue_cnt = 0;
   logic ovf = 1'b0;
   logic [23:0] sb [$];

   always #5 clk_i = ~clk_i;

   instr_fetch_unit dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rom_en_o     (rom_en),
      .rom_addr_o   (rom_addr),
      .rom_data_i   (rom_data),
      .byte_out_o   (byte_out),
      .byte_pc_o    (byte_pc),
      .byte_valid_o (byte_valid),
      .byte_ready_i (byte_ready),
      .jump_en_i    (jump_en),
      .jump_addr_i  (jump_addr),
      .halt_i       (halt),
      .halted_o     (halted)
   );

   function automatic logic [7:0] rom_f(input logic [15:0] a);
      case (a)
         16'h0000: rom_f = 8'h01;
         16'h0001: rom_f = 8'hA3;
         16'h0002: rom_f = 8'h5C;
         default:  rom_f = (a[7:0] * 8'd37) ^ a[15:8] ^ 8'h11;
      endcase
   endfunction

   always @(posedge clk_i) begin
      if (rom_en) rom_data <= rom_f(rom_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic sb_load(input logic [15:0] start, input int n);
      logic [15:0] pc;
      sb.delete();
      pc = start;
      for (int i = 0; i < n; i++) begin
         sb.push_back({pc, rom_f(pc)});
         pc = pc + 16'd1;
      end
   endtask

   task automatic nxt();
      @(posedge clk_i);
      #1;
   endtask

   // Pops are compared in program order against the expected stream.
   always @(negedge clk_i) begin
      logic [23:0] e;
      if (!rst_i && byte_valid && byte_ready && !jump_en) begin
         pop_cnt++;
         if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("sb_byte", {8'h0, byte_pc, byte_out}, {8'h0, e});
         end
      end
      if (rom_en) issue_cnt++;
      if (dut.count_q > 3'd4) ovf = 1'b1;
   end

   // Drives a one-cycle jump and checks the first post-jump byte latency.
   task automatic do_jump(input logic [15:0] addr);
      jump_en = 1'b1;
      jump_addr = addr;
      byte_ready = 1'b1;
      sb_load(addr, 64);
      @(negedge clk_i);
      chk("jump_no_issue", {31'd0, rom_en}, 32'd0);
      nxt();
      jump_en = 1'b0;
      for (int k = 1; k <= LAT_J; k++) begin
         @(negedge clk_i);
         if (k == 1) chk("jump_unhalt", {31'd0, halted}, 32'd0);
         if (k < LAT_J) chk("jump_no_stale", {31'd0, byte_valid}, 32'd0);
         else begin
            chk("jump_first_valid", {31'd0, byte_valid}, 32'd1);
            chk("jump_first_byte", {24'd0, byte_out}, {24'd0, rom_f(addr)});
            chk("jump_first_pc", {16'd0, byte_pc}, {16'd0, addr});
         end
         nxt();
      end
   endtask

   initial begin
      int i0, p0;
      logic [15:0] ep;
      rst_i = 1'b1; byte_ready = 1'b0; jump_en = 1'b0; jump_addr = '0; halt = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_rom_en", {31'd0, rom_en}, 32'd0);
      chk("rst_rom_addr", {16'd0, rom_addr}, 32'd0);
      chk("rst_valid", {31'd0, byte_valid}, 32'd0);
      chk("rst_byte_out", {24'd0, byte_out}, 32'd0);
      chk("rst_byte_pc", {16'd0, byte_pc}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);

      // Streaming from reset with continuous pops.
      nxt();
      rst_i = 1'b0; byte_ready = 1'b1;
      sb_load(16'h0000, 64);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         chk("s1_rom_en", {31'd0, rom_en}, 32'd1);
         chk("s1_rom_addr", {16'd0, rom_addr}, k);
         if (k >= LAT) begin
            chk("s1_byte_out", {24'd0, byte_out}, {24'd0, rom_f(16'(k - LAT))});
            chk("s1_byte_pc", {16'd0, byte_pc}, k - LAT);
         end else chk("s1_not_valid", {31'd0, byte_valid}, 32'd0);
         nxt();
      end

      // Back-pressure from reset: credit limits reads to FIFO_DEPTH.
      rst_i = 1'b1;
      nxt();
      rst_i = 1'b0; byte_ready = 1'b0;
      sb_load(16'h0000, 64);
      i0 = issue_cnt;
      repeat (10) nxt();
      chk("s2_issue_cnt", issue_cnt - i0, 32'd4);
      @(negedge clk_i);
      chk("s2_rom_en_idle", {31'd0, rom_en}, 32'd0);
      chk("s2_valid", {31'd0, byte_valid}, 32'd1);
      chk("s2_byte_out", {24'd0, byte_out}, 32'h01);
      chk("s2_byte_pc", {16'd0, byte_pc}, 32'd0);
      nxt();
      byte_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_i);
         chk("s2_no_gap", {31'd0, byte_valid}, 32'd1);
         nxt();
      end

      // Jump with a read in flight and two bytes queued.
      do_jump(16'h0040);
      repeat (6) nxt();

      // Wrap of byte_pc across 2**16.
      do_jump(16'hFFFE);
      ep = 16'hFFFF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         chk("s4_wrap_pc", {16'd0, byte_pc}, {16'd0, ep});
         ep = ep + 16'd1;
         nxt();
      end

      // Halt with two queued bytes and one in flight.
      byte_ready = 1'b0;
      nxt();
      halt = 1'b1;
      @(negedge clk_i);
      chk("s5_halted_late", {31'd0, halted}, 32'd0);
      chk("s5_halt_no_issue", {31'd0, rom_en}, 32'd0);
      nxt();
      halt = 1'b0; byte_ready = 1'b1;
      p0 = pop_cnt;
      i0 = issue_cnt;
      @(negedge clk_i);
      chk("s5_halted", {31'd0, halted}, 32'd1);
      repeat (8) nxt();
      chk("s5_drained", pop_cnt - p0, 32'd3);
      chk("s5_no_issue", issue_cnt - i0, 32'd0);
      @(negedge clk_i);
      chk("s5_empty", {31'd0, byte_valid}, 32'd0);
      chk("s5_still_halted", {31'd0, halted}, 32'd1);
      nxt();
      do_jump(16'h0100);
      repeat (4) nxt();

      // Reset overrides a simultaneous jump.
      rst_i = 1'b1; jump_en = 1'b1; jump_addr = 16'h0200;
      sb_load(16'h0000, 64);
      nxt();
      rst_i = 1'b0; jump_en = 1'b0;
      p0 = pop_cnt;
      @(negedge clk_i);
      chk("s6_valid", {31'd0, byte_valid}, 32'd0);
      chk("s6_byte_pc", {16'd0, byte_pc}, 32'd0);
      chk("s6_rom_en", {31'd0, rom_en}, 32'd1);
      chk("s6_rom_addr", {16'd0, rom_addr}, 32'd0);
      chk("s6_halted", {31'd0, halted}, 32'd0);
      repeat (8) nxt();
      chk("s6_pops", pop_cnt - p0, 8 - LAT);

      chk("no_overflow", {31'd0, ovf}, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
